// File: rtl/emulate_stream_out_pkg.sv
// Shared constants and types for the stream-in / stream-out emulators.
// Holds the default stream geometry, the header word, and the framing state enum.
// Also holds a saturating increment used by the status counters.
package emulate_stream_out_pkg;
    localparam int          PHIT_SIZE_DEF     = 512;
    localparam int          PACKET_LENGTH_DEF = 8;
    localparam logic [31:0] PKT_HEADER_WORD   = 32'h1234_5678;
    localparam int          LANES             = PHIT_SIZE_DEF / 32;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        DRAIN
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/emulate_stream_out_bp.sv
// stream_bp_gen: pseudo-random backpressure for the stream-out sink.
// Ports: clk, rst (async, active-high), bp_en in; tready out (registered).
// 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle; tready ~75% duty when enabled.
module stream_bp_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic bp_en,
    output logic tready
);
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;

    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tready_d = bp_en ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q   <= LFSR_SEED;
            tready_q <= 1'b1;
        end else begin
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
        end
    end

    assign tready = tready_q;
endmodule

// File: rtl/float_generator.sv
// Expected payload source: IEEE-754 single-precision value of the integer idx.
// Ports: idx (beat index, 0..31) in; value (float bit pattern) out.
// Purely combinational; idx=0 yields +0.0.
module float_generator (
    input  logic [4:0]  idx,
    output logic [31:0] value
);
    logic [2:0]  msb;
    logic [22:0] mant;

    always_comb begin
        msb = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (idx[i]) msb = 3'(i);
        end
        // Shifting the leading one to bit 23 pushes it out of the 23-bit
        // field, leaving only the fraction bits.
        mant  = {18'd0, idx} << (23 - int'(msb));
        value = (idx == 5'd0) ? 32'd0 : {1'b0, 8'd127 + {5'd0, msb}, mant};
    end
endmodule

// File: rtl/emulate_stream_out.sv
// AXI4-Stream sink: checks packet framing/payload, keeps counters, sticky error flags, checksum.
// Ports: ap_clk/ap_rst, axis_* stream slave, bp_en in; pkt_count, err_count, err_*, checksum, pkt_done out.
// Status appears one cycle after the accepting edge; tready is registered, optionally LFSR-throttled.
module emulate_stream_out
    import emulate_stream_out_pkg::*;
#(
    parameter int          PHIT_SIZE     = PHIT_SIZE_DEF,
    parameter int          PACKET_LENGTH = PACKET_LENGTH_DEF,
    parameter logic [31:0] HEADER_WORD   = PKT_HEADER_WORD,
    parameter bit          CHECK_PAYLOAD = 1'b1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [PHIT_SIZE-1:0]   axis_tdata,
    input  logic                   axis_tvalid,
    output logic                   axis_tready,
    input  logic                   axis_tlast,
    input  logic [PHIT_SIZE/8-1:0] axis_tkeep,
    input  logic                   bp_en,
    output logic [31:0]            pkt_count,
    output logic [31:0]            err_count,
    output logic                   err_hdr,
    output logic                   err_len,
    output logic                   err_keep,
    output logic                   err_data,
    output logic [31:0]            checksum,
    output logic                   pkt_done
);
    localparam int          NLANES   = PHIT_SIZE / 32;
    localparam logic [31:0] LAST_IDX = 32'(PACKET_LENGTH - 1);

    state_t      state_q, state_d;
    logic [31:0] beat_idx_q, beat_idx_d;
    logic        bad_q, bad_d;
    logic [31:0] run_sum_q, run_sum_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic [31:0] checksum_q, checksum_d;
    logic        err_hdr_q, err_hdr_d, err_len_q, err_len_d;
    logic        err_keep_q, err_keep_d, err_data_q, err_data_d;
    logic        pkt_done_q, pkt_done_d;

    logic        accept, end_pkt, end_bad, lane_bad, keep_bad, data_bad;
    logic [31:0] lane0, expected;

    stream_bp_gen #(.LFSR_SEED(LFSR_SEED)) u_bp (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .bp_en  (bp_en),
        .tready (axis_tready)
    );

    float_generator u_fg (
        .idx   (beat_idx_q[4:0]),
        .value (expected)
    );

    assign accept = axis_tvalid && axis_tready;
    assign lane0  = axis_tdata[31:0];

    always_comb begin
        lane_bad = 1'b0;
        for (int l = 1; l < NLANES; l++) begin
            if (axis_tdata[l*32 +: 32] != lane0) lane_bad = 1'b1;
        end
        keep_bad = (axis_tkeep != '1);
        data_bad = lane_bad || (CHECK_PAYLOAD && (lane0 != expected));
    end

    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        bad_d       = bad_q;
        run_sum_d   = run_sum_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        checksum_d  = checksum_q;
        err_hdr_d   = err_hdr_q;
        err_len_d   = err_len_q;
        err_keep_d  = err_keep_q;
        err_data_d  = err_data_q;
        pkt_done_d  = 1'b0;
        end_pkt     = 1'b0;
        end_bad     = 1'b0;

        if (accept) begin
            unique case (state_q)
                HDR: begin
                    bad_d      = 1'b0;
                    run_sum_d  = 32'd0;
                    beat_idx_d = 32'd0;
                    if (lane0 != HEADER_WORD) begin
                        err_hdr_d = 1'b1;
                        bad_d     = 1'b1;
                        state_d   = DRAIN;
                    end
                    // A one-beat packet ends here regardless of header validity.
                    if (axis_tlast) begin
                        err_len_d = 1'b1;
                        end_pkt   = 1'b1;
                        end_bad   = 1'b1;
                        state_d   = HDR;
                    end else if (lane0 == HEADER_WORD) begin
                        state_d    = PAY;
                        beat_idx_d = 32'd1;
                    end
                end
                PAY: begin
                    if (keep_bad) err_keep_d = 1'b1;
                    if (data_bad) err_data_d = 1'b1;
                    bad_d      = bad_q || keep_bad || data_bad;
                    run_sum_d  = run_sum_q ^ lane0;
                    beat_idx_d = beat_idx_q + 32'd1;
                    if (axis_tlast && (beat_idx_q < LAST_IDX)) begin
                        err_len_d = 1'b1;
                        end_pkt   = 1'b1;
                        end_bad   = 1'b1;
                        state_d   = HDR;
                    end else if (beat_idx_q == LAST_IDX) begin
                        if (axis_tlast) begin
                            end_pkt = 1'b1;
                            end_bad = bad_d;
                            state_d = HDR;
                        end else begin
                            err_len_d = 1'b1;
                            bad_d     = 1'b1;
                            state_d   = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (axis_tlast) begin
                        end_pkt = 1'b1;
                        end_bad = 1'b1;
                        state_d = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end

        if (end_pkt) begin
            pkt_done_d = 1'b1;
            beat_idx_d = 32'd0;
            if (end_bad) begin
                err_count_d = sat_inc(err_count_q);
            end else begin
                pkt_count_d = sat_inc(pkt_count_q);
                checksum_d  = run_sum_d;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= HDR;
            beat_idx_q  <= 32'd0;
            bad_q       <= 1'b0;
            run_sum_q   <= 32'd0;
            pkt_count_q <= 32'd0;
            err_count_q <= 32'd0;
            checksum_q  <= 32'd0;
            err_hdr_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_keep_q  <= 1'b0;
            err_data_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            bad_q       <= bad_d;
            run_sum_q   <= run_sum_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            checksum_q  <= checksum_d;
            err_hdr_q   <= err_hdr_d;
            err_len_q   <= err_len_d;
            err_keep_q  <= err_keep_d;
            err_data_q  <= err_data_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
    assign checksum  = checksum_q;
    assign err_hdr   = err_hdr_q;
    assign err_len   = err_len_q;
    assign err_keep  = err_keep_q;
    assign err_data  = err_data_q;
    assign pkt_done  = pkt_done_q;
endmodule

// File: doc/emulate_stream_out.md
# emulate_stream_out

Testbench-side AXI4-Stream sink for the CGRA output port. It terminates the output stream, checks packet framing, optionally checks payload against the same float sequence the stream-in emulator injects, and exposes counters and sticky error flags. It sits opposite the stream-in emulator on the kernel's axis01 output and can apply pseudo-random backpressure.

## Interface
- PHIT_SIZE, 512: stream data width in bits; multiple of 32.
- PACKET_LENGTH, 8: beats per packet including header; ≥ 2.
- HEADER_WORD, 32'h12345678: required value of tdata[31:0] on the header beat.
- CHECK_PAYLOAD, 1: 1 compares payload lane 0 with float_generator output; 0 runs lane-consistency checks only.
- LFSR_SEED, 16'hACE1: backpressure LFSR seed; must be non-zero.
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous, active-high reset.
- axis_tdata  in  PHIT_SIZE  stream data.
- axis_tvalid  in  1  beat valid.
- axis_tready  out  1  sink ready.
- axis_tlast  in  1  last beat of packet.
- axis_tkeep  in  PHIT_SIZE/8  byte enables.
- bp_en  in  1  1 = pseudo-random backpressure; 0 = tready held high.
- pkt_count  out  32  good packets received, saturating.
- err_count  out  32  bad packets, saturating.
- err_hdr / err_len / err_keep / err_data  out  1 each  sticky error flags.
- checksum  out  32  XOR of payload lane-0 words in the last good packet.
- pkt_done  out  1  one-cycle pulse per packet end; good or bad.

## Operation
- Accept a beat only when axis_tvalid && axis_tready. Beats with tvalid low are ignored.
- beat_idx counts accepted beats in the current packet: 0 on the header beat, 1 to PACKET_LENGTH-1 on payload beats.
- States:
  - HDR: expect the header beat.
  - PAY: accept payload beats.
  - DRAIN: discard beats until tlast.
- In HDR, on an accepted beat:
  - tdata[31:0] ≠ HEADER_WORD: set err_hdr, mark the packet bad, go to DRAIN.
  - tlast=1 on the header beat: set err_len, end the packet as bad, stay in HDR. This takes priority over the DRAIN move.
  - Otherwise go to PAY with beat_idx=1.
- In PAY, on each accepted beat:
  - tkeep ≠ all-ones: set err_keep and mark the packet bad.
  - Any 32-bit lane differs from lane 0: set err_data and mark bad.
  - CHECK_PAYLOAD=1 and lane 0 ≠ float_generator(beat_idx[4:0]): set err_data and mark bad.
  - XOR lane 0 into the running checksum.
  - None of these errors forces DRAIN.
- Length checks in PAY:
  - tlast=1 with beat_idx < PACKET_LENGTH-1: set err_len, end bad, go to HDR.
  - beat_idx = PACKET_LENGTH-1 with tlast=0: set err_len, mark bad, go to DRAIN.
  - beat_idx = PACKET_LENGTH-1 with tlast=1: end the packet, go to HDR.
- In DRAIN, beats are discarded without checks; tlast=1 ends the packet as bad and returns to HDR.
- Packet end:
  - Good packet: pkt_count+1 and checksum latched.
  - Bad packet: err_count+1 and checksum unchanged.
  - pkt_done pulses in either case.
- Counters saturate at 32'hFFFF_FFFF. Sticky flags clear only on reset.
- Backpressure: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. With bp_en=1, next axis_tready = LFSR[0] | LFSR[1], about 75% duty.

## Timing
- Reset value of every output is 0, except axis_tready, which resets to 1. The LFSR loads LFSR_SEED; state resets to HDR, beat_idx to 0, running checksum to 0.
- axis_tready is registered. With bp_en=0 it is 1 every cycle after reset. A change on bp_en takes effect on the next clock edge.
- Status latency: the flags, counters, checksum and pkt_done caused by an accepted beat are visible 1 cycle after the accepting edge.
- pkt_done is high for exactly one cycle per packet end, including back-to-back packets with no idle cycle.
- Reset asserted mid-packet aborts the packet without counting it. The first accepted beat after reset release is treated as a header.
- Several error flags may set on the same beat. err_count increments at most once per packet.

## Structure
- Shared package holds the following; this block and the stream-in emulator both import it:
  - PHIT_SIZE and PACKET_LENGTH defaults;
  - HEADER_WORD;
  - the state enum {HDR, PAY, DRAIN};
  - a LANES = PHIT_SIZE/32 constant.
- Reuse the existing float_generator for the expected payload value.
- One new sub-module: stream_bp_gen, which contains the LFSR and the registered tready generation.

## Test plan
- bp_en=0; 3 well-formed 8-beat packets from the stream-in emulator → pkt_count=3, err_count=0, all flags 0, 3 pkt_done pulses; checksum = XOR of float_generator(1..7).
- bp_en=1; 100 packets → pkt_count=100; no beat lost or duplicated; tready low on about 25% of cycles.
- Header word 32'hDEADBEEF, then a good packet → err_hdr=1, err_count=1, pkt_count=1; the first packet's 8 beats are drained.
- tlast on beat 4, then a good packet; separately, a 10-beat packet with tlast on beat 9 → err_len=1. The short packet ends at beat 4 and the next header is accepted. The long packet drains until tlast. Each bad packet adds 1 to err_count.
- tkeep=0 on beat 3, and lane 5 corrupted on beat 6 of another packet → err_keep=1, err_data=1, err_count=2, no DRAIN.
- Reset asserted at beat 3 of a packet, then 2 good packets → counters 0 after reset, then pkt_count=2, err_count=0.
